wreg_queue: RTL and testbench
=============================

WREG_QUEUE -- requirements
Module: wreg_queue

Interface
REQ-001 SHALL provide parameter ADDR_W, default 5, meaning register-address width.
REQ-002 SHALL provide parameter DEPTH, default 4, meaning queue entries; legal values are powers of two, 2..16.
REQ-003 SHALL provide parameter SP_REG, default 29, meaning the constant destination for selector 01.
REQ-004 SHALL provide parameter RA_REG, default 31, meaning the constant destination for selector 10.
REQ-005 SHALL provide clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL provide reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL provide selector, input, 2, the destination source select.
REQ-008 SHALL provide rt, input, ADDR_W, the destination candidate from instruction[20..16].
REQ-009 SHALL provide rd, input, ADDR_W, the destination candidate from instruction[15..11].
REQ-010 SHALL provide push, input, 1, a request to enqueue dest_sel as a pending write.
REQ-011 SHALL provide pop, input, 1, a request to retire the head entry (writeback done).
REQ-012 SHALL provide src_a and src_b, inputs, ADDR_W each, the read addresses to check for hazards.
REQ-013 SHALL provide err_clr, input, 1, which clears the sticky error flag.
REQ-014 SHALL provide dest_sel, output, ADDR_W, the combinational selected destination.
REQ-015 SHALL provide wb_addr, output, ADDR_W, the head entry address; wb_valid, output, 1, high when the queue is non-empty.
REQ-016 SHALL provide full and empty, outputs, 1 each; count, output, $clog2(DEPTH)+1, the occupancy.
REQ-017 SHALL provide hazard_a and hazard_b, outputs, 1 each, and err, output, 1, the sticky misuse flag.

Function
REQ-018 dest_sel SHALL be rt for selector 00, SP_REG for 01, RA_REG for 10 and rd for 11; constants SHALL be truncated to ADDR_W.
REQ-019 A push with full=0 SHALL write dest_sel at the tail and advance the tail pointer modulo DEPTH.
REQ-020 A pop with empty=0 SHALL advance the head pointer modulo DEPTH; wb_addr SHALL show the new head in the following cycle.
REQ-021 A push with full=1 and pop=0 SHALL be ignored (contents and count unchanged) and SHALL set err.
REQ-022 A pop with empty=1 SHALL be ignored and SHALL set err; a simultaneous push in that cycle SHALL still be accepted.
REQ-023 Simultaneous push and pop with full=1 SHALL perform both operations; count SHALL stay at DEPTH and err SHALL NOT be set.
REQ-024 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged.
REQ-025 count SHALL be registered; full SHALL equal (count==DEPTH) and empty SHALL equal (count==0).
REQ-026 wb_addr and wb_valid SHALL be combinational from the head entry and empty; wb_addr SHALL be 0 when empty.
REQ-027 hazard_a SHALL be combinational: high when src_a!=0 and any occupied entry equals src_a; hazard_b SHALL behave identically for src_b.
REQ-028 Entries with address 0 SHALL be queued and retired normally but SHALL never raise a hazard.
REQ-029 Hazard checks SHALL reflect registered queue state only; an entry being pushed in the current cycle SHALL NOT raise a hazard until the next cycle.
REQ-030 err SHALL remain high until err_clr or reset; err_clr together with a new misuse event SHALL leave err high.

Reset
REQ-031 reset high SHALL immediately set count=0, head=tail=0, err=0, empty=1, full=0, wb_valid=0, wb_addr=0 and hazard_a=hazard_b=0, regardless of clk.
REQ-032 Reset asserted mid-operation SHALL discard all entries, and any push or pop sampled while reset is high SHALL be ignored.
REQ-033 Stored entry contents need not be cleared by reset, because unoccupied entries are never observable.

Verification
REQ-034 selector=00..11 with rt=7 and rd=12 (defaults) -> dest_sel = 7, 29, 31, 12.
REQ-035 Push rt=3, rt=5, SP, RA (DEPTH=4) -> full=1, count=4, wb_addr=3; then pop -> wb_addr=5, count=3, full=0.
REQ-036 Full queue, push+pop with rd=9 -> count=4, err=0, and after three further pops wb_addr=9.
REQ-037 Empty queue pop -> err=1, count=0; err_clr -> err=0; push of 0 then src_a=0 -> hazard_a=0.
REQ-038 Queue holds {4,8}: src_a=8, src_b=6 -> hazard_a=1, hazard_b=0; pop twice -> hazard_a=0.
REQ-039 Queue holds 3 entries and reset pulses between clock edges -> empty=1 and count=0 immediately; next push of rt=2 -> wb_addr=2, count=1.

Source files
------------

// File: rtl/wreg_queue_if.sv
// Pending-write queue bus: destination select, queue control, hazard
// probes and status. The master drives requests, the slave (the queue)
// returns status.
interface wreg_queue_if #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [1:0]        selector;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic              err_clr;

    logic [ADDR_W-1:0] dest_sel;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_valid;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              hazard_a;
    logic              hazard_b;
    logic              err;

    modport master (
        output selector, rt, rd, push, pop, src_a, src_b, err_clr,
        input  dest_sel, wb_addr, wb_valid, full, empty, count,
               hazard_a, hazard_b, err
    );

    modport slave (
        input  selector, rt, rd, push, pop, src_a, src_b, err_clr,
        output dest_sel, wb_addr, wb_valid, full, empty, count,
               hazard_a, hazard_b, err
    );
endinterface

// File: rtl/wreg_queue.sv
// Pending register-write queue. Selects the destination register of an
// instruction, holds it until writeback retires it, and flags read-after-
// write hazards against the registered (already queued) destinations.
// Misuse (push when full without pop, pop when empty) is ignored and
// latched into a sticky error flag.
module wreg_queue #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4,
    parameter int SP_REG = 29,
    parameter int RA_REG = 31
) (
    input  logic         clk,
    input  logic         reset,
    wreg_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_REG);
    localparam logic [ADDR_W-1:0] RA_ADDR = ADDR_W'(RA_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;
    logic              err_q;

    logic [ADDR_W-1:0] dest_sel;
    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;
    logic              err_set;
    logic [DEPTH-1:0]  occupied;
    logic              hazard_a;
    logic              hazard_b;

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside it.
    assign push_ok = bus.push && (!full || bus.pop);
    assign pop_ok  = bus.pop && !empty;
    assign err_set = (bus.push && full && !bus.pop) || (bus.pop && empty);

    // Destination source select; constants are truncated to the address width.
    always_comb begin
        dest_sel = bus.rt;
        case (bus.selector)
            2'b00:   dest_sel = bus.rt;
            2'b01:   dest_sel = SP_ADDR;
            2'b10:   dest_sel = RA_ADDR;
            default: dest_sel = bus.rd;
        endcase
    end

    // Entry storage; stale slots are never observable, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[tail] <= dest_sel;
        end
    end

    // Pointers and occupancy; pointer width makes wrap modulo DEPTH implicit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop_ok)  head <= head + 1'b1;
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Sticky misuse flag; a new misuse wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (bus.err_clr) begin
            err_q <= 1'b0;
        end
    end

    // Hazard match over occupied slots only; register 0 never hazards.
    always_comb begin
        occupied = '0;
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = ({1'b0, PTR_W'(i) - head} < count_q);
            if (occupied[i] && (bus.src_a != '0) && (mem[i] == bus.src_a)) hazard_a = 1'b1;
            if (occupied[i] && (bus.src_b != '0) && (mem[i] == bus.src_b)) hazard_b = 1'b1;
        end
    end

    assign bus.dest_sel = dest_sel;
    assign bus.wb_addr  = empty ? '0 : mem[head];
    assign bus.wb_valid = !empty;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.hazard_a = hazard_a;
    assign bus.hazard_b = hazard_b;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_wreg_queue.sv
// Directed bench for wreg_queue (ADDR_W=5, DEPTH=4): destination select,
// fill/drain with wrap, misuse and sticky error, hazards, async reset.
module tb_wreg_queue;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wreg_queue_if #(.ADDR_W(5), .DEPTH(4)) bus ();

    wreg_queue #(.ADDR_W(5), .DEPTH(4), .SP_REG(29), .RA_REG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
    endtask

    task automatic push_rt(input logic [4:0] v);
        bus.selector = 2'b00; bus.rt = v; bus.push = 1'b1;
        cycle();
        bus.push = 1'b0;
    endtask

    task automatic pop1();
        bus.pop = 1'b1;
        cycle();
        bus.pop = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.selector = 2'b00; bus.rt = '0; bus.rd = '0;
        bus.src_a = '0; bus.src_b = '0;
        idle();
        #2;
        chk("rst_count",    32'(bus.count),    0);
        chk("rst_empty",    32'(bus.empty),    1);
        chk("rst_full",     32'(bus.full),     0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 0);
        chk("rst_wb_addr",  32'(bus.wb_addr),  0);
        chk("rst_err",      32'(bus.err),      0);
        cycle();
        cycle();
        reset = 1'b0;

        // destination select
        bus.rt = 5'd7; bus.rd = 5'd12;
        bus.selector = 2'b00; #1 chk("sel00", 32'(bus.dest_sel), 7);
        bus.selector = 2'b01; #1 chk("sel01", 32'(bus.dest_sel), 29);
        bus.selector = 2'b10; #1 chk("sel10", 32'(bus.dest_sel), 31);
        bus.selector = 2'b11; #1 chk("sel11", 32'(bus.dest_sel), 12);
        cycle();

        // fill: 3, 5, SP, RA
        push_rt(5'd3);
        push_rt(5'd5);
        bus.selector = 2'b01; bus.push = 1'b1; cycle();
        bus.selector = 2'b10; cycle();
        idle();
        chk("fill_full",  32'(bus.full),    1);
        chk("fill_count", 32'(bus.count),   4);
        chk("fill_wb",    32'(bus.wb_addr), 3);
        bus.src_a = 5'd29; bus.src_b = 5'd30; #1;
        chk("fill_haz_a", 32'(bus.hazard_a), 1);
        chk("fill_haz_b", 32'(bus.hazard_b), 0);

        // push while full without pop: ignored, err set
        push_rt(5'd17);
        chk("ovf_err",   32'(bus.err),     1);
        chk("ovf_count", 32'(bus.count),   4);
        chk("ovf_wb",    32'(bus.wb_addr), 3);
        bus.src_a = 5'd17; #1;
        chk("ovf_nohaz", 32'(bus.hazard_a), 0);
        bus.err_clr = 1'b1; cycle(); bus.err_clr = 1'b0;
        chk("clr_err", 32'(bus.err), 0);

        pop1();
        chk("pop_wb",    32'(bus.wb_addr), 5);
        chk("pop_count", 32'(bus.count),   3);
        chk("pop_full",  32'(bus.full),    0);

        // refill to {5,29,31,6}, then push rd=9 with pop while full
        push_rt(5'd6);
        chk("refill_full", 32'(bus.full), 1);
        bus.selector = 2'b11; bus.rd = 5'd9; bus.push = 1'b1; bus.pop = 1'b1;
        cycle();
        idle();
        chk("pp_count", 32'(bus.count),   4);
        chk("pp_err",   32'(bus.err),     0);
        chk("pp_wb",    32'(bus.wb_addr), 29);
        pop1(); pop1(); pop1();
        chk("pp3_wb",    32'(bus.wb_addr), 9);
        chk("pp3_count", 32'(bus.count),   1);
        pop1();
        chk("drain_empty", 32'(bus.empty),    1);
        chk("drain_wb",    32'(bus.wb_addr),  0);
        chk("drain_valid", 32'(bus.wb_valid), 0);

        // underflow
        pop1();
        chk("udf_err",   32'(bus.err),   1);
        chk("udf_count", 32'(bus.count), 0);
        bus.err_clr = 1'b1; cycle(); bus.err_clr = 1'b0;
        chk("udf_clr", 32'(bus.err), 0);
        bus.err_clr = 1'b1; bus.pop = 1'b1; cycle(); idle();
        chk("clr_vs_set", 32'(bus.err), 1);

        // pop on empty with push of register 0: push accepted, err set
        bus.err_clr = 1'b1; cycle(); bus.err_clr = 1'b0;
        bus.selector = 2'b00; bus.rt = 5'd0; bus.push = 1'b1; bus.pop = 1'b1;
        cycle();
        idle();
        chk("z_count", 32'(bus.count),    1);
        chk("z_err",   32'(bus.err),      1);
        chk("z_valid", 32'(bus.wb_valid), 1);
        chk("z_wb",    32'(bus.wb_addr),  0);
        bus.src_a = 5'd0; #1;
        chk("z_haz", 32'(bus.hazard_a), 0);
        pop1();
        bus.err_clr = 1'b1; cycle(); bus.err_clr = 1'b0;

        // hazards against {4,8}, then a same-cycle push of 6
        push_rt(5'd4);
        push_rt(5'd8);
        bus.src_a = 5'd8; bus.src_b = 5'd6; #1;
        chk("h_a", 32'(bus.hazard_a), 1);
        chk("h_b", 32'(bus.hazard_b), 0);
        bus.selector = 2'b00; bus.rt = 5'd6; bus.push = 1'b1; #1;
        chk("h_b_pushing", 32'(bus.hazard_b), 0);
        cycle();
        idle();
        chk("h_b_next", 32'(bus.hazard_b), 1);
        pop1(); pop1();
        chk("h_a_gone", 32'(bus.hazard_a), 0);
        chk("h_b_kept", 32'(bus.hazard_b), 1);

        // async reset between edges with three entries {6,1,2}
        push_rt(5'd1);
        push_rt(5'd2);
        chk("pre_rst_count", 32'(bus.count), 3);
        #2 reset = 1'b1;
        #1;
        chk("ar_empty", 32'(bus.empty),    1);
        chk("ar_count", 32'(bus.count),    0);
        chk("ar_valid", 32'(bus.wb_valid), 0);
        chk("ar_haz_b", 32'(bus.hazard_b), 0);
        #1 reset = 1'b0;
        cycle();
        // push sampled while reset is high is ignored
        reset = 1'b1; bus.selector = 2'b00; bus.rt = 5'd11; bus.push = 1'b1;
        cycle();
        idle();
        reset = 1'b0;
        #1;
        chk("rst_push_ign", 32'(bus.count), 0);
        push_rt(5'd2);
        chk("post_wb",    32'(bus.wb_addr), 2);
        chk("post_count", 32'(bus.count),   1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
